// File: rtl/instruction_memory_pipelined.sv
// Instruction memory for the fetch stage: INIT sweep to NOP, run-time load port, 1-cycle fetch.
// Optional per-word even parity when IMEM_PARITY_EN is defined (adds parity_err_o).
module instruction_memory_pipelined #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] address_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  misaligned_o,
  output logic                  out_of_range_o,
  input  logic                  load_en_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  init_done_o
`ifdef IMEM_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        init_cnt_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic                    mis_q;
  logic                    oor_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    run;
  logic                    init_last;
  logic [IDX_W-1:0]        fetch_idx;
  logic                    fetch_mis;
  logic                    fetch_oor;
  logic                    fetch_acc;
  logic [IDX_W-1:0]        load_idx;
  logic                    load_ok;
  logic                    bypass;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   raw_word;
  logic                    par_bad;
  logic [DATA_WIDTH-1:0]   rd_data_d;
  logic                    unused_load_lsb;

`ifdef IMEM_PARITY_EN
  logic                    par_q [DEPTH];
  logic                    par_err_q;
  logic                    par_err_d;
`endif

  assign run       = (state_q == ST_RUN);
  assign init_last = (init_cnt_q == IDX_W'(DEPTH - 1));

  assign fetch_idx = address_i[IDX_W+1:2];
  assign fetch_mis = |address_i[1:0];
  assign fetch_oor = (address_i >> (IDX_W + 2)) != '0;

  assign load_idx        = load_addr_i[IDX_W+1:2];
  assign load_ok         = (load_addr_i >> (IDX_W + 2)) == '0;
  assign unused_load_lsb = ^load_addr_i[1:0];

  // Single output register: a new request may enter in the same cycle the held one drains.
  assign req_ready_o = run && (!rsp_valid_q || rsp_ready_i);
  assign fetch_acc   = req_valid_i && req_ready_o;

  assign wr_en   = run ? (load_en_i && load_ok) : 1'b1;
  assign wr_idx  = run ? load_idx : init_cnt_q;
  assign wr_data = run ? load_data_i : '0;
  assign bypass  = run && load_en_i && load_ok && (load_idx == fetch_idx);

  always_comb begin
    raw_word = bypass ? load_data_i : mem_q[fetch_idx];
    par_bad  = 1'b0;
`ifdef IMEM_PARITY_EN
    if (!bypass) begin
      par_bad = (par_q[fetch_idx] != ^mem_q[fetch_idx]);
    end
    par_err_d = !fetch_mis && !fetch_oor && par_bad;
`endif
    rd_data_d = (fetch_mis || fetch_oor || par_bad) ? '0 : raw_word;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
      par_q[wr_idx] <= ^wr_data;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      instr_q     <= '0;
      mis_q       <= 1'b0;
      oor_q       <= 1'b0;
`ifdef IMEM_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + IDX_W'(1);
          if (init_last) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fetch_acc) begin
            rsp_valid_q <= 1'b1;
            instr_q     <= rd_data_d;
            mis_q       <= fetch_mis;
            oor_q       <= fetch_oor;
`ifdef IMEM_PARITY_EN
            par_err_q   <= par_err_d;
`endif
          end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign instruction_o  = instr_q;
  assign misaligned_o   = mis_q;
  assign out_of_range_o = oor_q;
  assign init_done_o    = run;
`ifdef IMEM_PARITY_EN
  assign parity_err_o   = par_err_q;
`endif

endmodule
